w0_update_sched: RTL and testbench

W0_UPDATE_SCHED -- requirements
Module: w0_update_sched

---
 rtl/w0_update_sched_pkg.sv | 21 ++
 rtl/w0_update_sched_level_quant.sv | 33 +++
 rtl/w0_update_sched.sv | 123 ++++++++++++
 tb/tb_w0_update_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/w0_update_sched_pkg.sv
// Shared types and constants for the W0 update scheduler.
// State encoding, level codes and default sizes live here.
package w0_update_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] LVL_M3 = 2'b00;
    localparam logic [1:0] LVL_P3 = 2'b01;
    localparam logic [1:0] LVL_M1 = 2'b10;
    localparam logic [1:0] LVL_P1 = 2'b11;

    localparam int W0_N_DEF    = 512;
    localparam int W_N_DEF     = 16;
    localparam int COEFF_W_DEF = 16;

endpackage

// File: rtl/w0_update_sched_level_quant.sv
// Combinational coefficient-to-level quantiser.
// Scales by an arithmetic right shift, then picks one of four levels.
module w0_level_quant
    import w0_update_sched_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int Q_SHIFT = 5
) (
    input  logic signed [COEFF_W-1:0] i_coeff,
    output logic        [1:0]         o_code
);

    localparam logic signed [COEFF_W-1:0] C_M2 = COEFF_W'(-2);
    localparam logic signed [COEFF_W-1:0] C_P2 = COEFF_W'(2);

    logic signed [COEFF_W-1:0] w_t;

    assign w_t = i_coeff >>> Q_SHIFT;

    // Map the scaled value onto the four-level alphabet
    always_comb begin
        o_code = LVL_P1;
        if (w_t <= C_M2)
            o_code = LVL_M3;
        else if (w_t[COEFF_W-1])
            o_code = LVL_M1;
        else if (w_t < C_P2)
            o_code = LVL_P1;
        else
            o_code = LVL_P3;
    end

endmodule

// File: rtl/w0_update_sched.sv
// Rewrites the full W0 LUT from the adaptive taps, one entry per cycle.
// Optional W0_UPDATE_SCHED_COALESCE_CNT_EN enables the coalesce counter.
module w0_update_sched
    import w0_update_sched_pkg::*;
#(
    parameter int W0_N       = W0_N_DEF,
    parameter int W_N        = W_N_DEF,
    parameter int COEFF_W    = COEFF_W_DEF,
    parameter int Q_SHIFT    = 5,
    parameter int IDX_OFFSET = 17
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable_in,
    input  logic                       lms_valid_in,
    output logic [$clog2(W_N)-1:0]     src_idx_out,
    input  logic signed [COEFF_W-1:0]  src_coeff_in,
    output logic                       upd_valid_out,
    output logic [$clog2(W0_N)-1:0]    upd_idx_out,
    output logic [1:0]                 upd_code_out,
    output logic                       commit_out,
    output logic                       busy_out,
    output logic [15:0]                coalesce_cnt_out
);

    localparam int D_W = $clog2(W0_N);
    localparam int S_W = $clog2(W_N);
    localparam int SH  = $clog2(W0_N / W_N);

    state_t                    r_state;
    logic                      r_pending;
    logic [D_W-1:0]            r_d;
    logic                      r_upd_valid;
    logic [D_W-1:0]            r_upd_idx;
    logic signed [COEFF_W-1:0] r_coeff;

    logic                      w_start;
    logic [D_W-1:0]            w_sum;
    logic [S_W-1:0]            w_src;
    logic [1:0]                w_code;

    assign w_start = (r_state == ST_IDLE) && enable_in &&
                     (lms_valid_in || r_pending);
    assign w_sum   = r_d + D_W'(IDX_OFFSET);
    assign w_src   = S_W'(w_sum >> SH);

    assign src_idx_out   = (r_state == ST_SWEEP) ? w_src : '0;
    assign upd_valid_out = r_upd_valid;
    assign upd_idx_out   = r_upd_idx;
    assign upd_code_out  = r_upd_valid ? w_code : LVL_P1;
    assign commit_out    = (r_state == ST_COMMIT);
    assign busy_out      = (r_state != ST_IDLE);

    w0_level_quant #(
        .COEFF_W (COEFF_W),
        .Q_SHIFT (Q_SHIFT)
    ) u_quant (
        .i_coeff (r_coeff),
        .o_code  (w_code)
    );

    // Sequencer: idle -> sweep all entries -> drain last update -> commit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_d       <= '0;
            r_pending <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SWEEP;
                        r_d     <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_d <= r_d + D_W'(1);
                    if (r_d == D_W'(W0_N - 1))
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN:  r_state <= ST_COMMIT;
                ST_COMMIT: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
            if (w_start)
                r_pending <= 1'b0;
            else if (lms_valid_in)
                r_pending <= 1'b1;
        end
    end

    // One-cycle pipeline: capture tap coefficient, emit update next cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_upd_valid <= 1'b0;
            r_upd_idx   <= '0;
            r_coeff     <= '0;
        end else begin
            r_upd_valid <= (r_state == ST_SWEEP);
            if (r_state == ST_SWEEP) begin
                r_upd_idx <= r_d;
                r_coeff   <= src_coeff_in;
            end
        end
    end

`ifdef W0_UPDATE_SCHED_COALESCE_CNT_EN
    logic [15:0] r_coal;

    // Count requests folded into an already-pending sweep
    always_ff @(posedge clock) begin
        if (reset)
            r_coal <= '0;
        else if (lms_valid_in && r_pending && (r_coal != 16'hFFFF))
            r_coal <= r_coal + 16'd1;
    end

    assign coalesce_cnt_out = r_coal;
`else
    assign coalesce_cnt_out = '0;
`endif

endmodule

// File: tb/tb_w0_update_sched.sv
// Self-checking bench for w0_update_sched.
// Random tap tables scored against a per-entry arithmetic model.
module tb_w0_update_sched;

    localparam int W0N = 512;
    localparam int WN  = 16;
    localparam int QS  = 5;
    localparam int OFF = 17;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable_in;
    logic               lms_valid_in;
    logic [3:0]         src_idx_out;
    logic signed [15:0] src_coeff_in;
    logic               upd_valid_out;
    logic [8:0]         upd_idx_out;
    logic [1:0]         upd_code_out;
    logic               commit_out;
    logic               busy_out;
    logic [15:0]        coalesce_cnt_out;

    int tbl [16];
    int n_chk = 0;
    int n_err = 0;
    int exp_idx = 0;
    int n_commit = 0;

    always #5 clock = ~clock;

    w0_update_sched dut (
        .clock            (clock),
        .reset            (reset),
        .enable_in        (enable_in),
        .lms_valid_in     (lms_valid_in),
        .src_idx_out      (src_idx_out),
        .src_coeff_in     (src_coeff_in),
        .upd_valid_out    (upd_valid_out),
        .upd_idx_out      (upd_idx_out),
        .upd_code_out     (upd_code_out),
        .commit_out       (commit_out),
        .busy_out         (busy_out),
        .coalesce_cnt_out (coalesce_cnt_out)
    );

    always_comb src_coeff_in = 16'(tbl[src_idx_out]);

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Level for a coefficient: floor-divide by 2^QS, then threshold
    function automatic int ref_code(input int c);
        int dv;
        int t;
        dv = 1 << QS;
        t  = (c >= 0) ? c / dv : -((-c + dv - 1) / dv);
        if (t <= -2) return 0;
        if (t < 0)   return 2;
        if (t < 2)   return 3;
        return 1;
    endfunction

    function automatic int ref_tap(input int d);
        return ((d + OFF) / (W0N / WN)) % WN;
    endfunction

    // Scoreboard: every update and commit checked against the model
    always @(negedge clock) begin
        if (reset) begin
            exp_idx = 0;
        end else begin
            if (upd_valid_out) begin
                chk("upd_idx", upd_idx_out, exp_idx);
                chk("upd_code", upd_code_out,
                    ref_code(tbl[ref_tap(exp_idx)]));
                exp_idx++;
            end
            if (commit_out) begin
                chk("pulses_per_commit", exp_idx, W0N);
                exp_idx = 0;
                n_commit++;
            end
            if (!busy_out) begin
                chk("idle_src", src_idx_out, 0);
                chk("idle_code", upd_code_out, 3);
                chk("idle_valid", upd_valid_out, 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_lms();
        lms_valid_in = 1'b1;
        step(1);
        lms_valid_in = 1'b0;
    endtask

    task automatic wait_commit(input string tag, input int limit,
                               output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1);
            if (commit_out) begin
                cyc = i;
                break;
            end
        end
        chk({tag, "_seen"}, (cyc > 0) ? 1 : 0, 1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"}, busy_out, 0);
        chk({pfx, "_valid"}, upd_valid_out, 0);
        chk({pfx, "_idx"}, upd_idx_out, 0);
        chk({pfx, "_code"}, upd_code_out, 3);
        chk({pfx, "_commit"}, commit_out, 0);
        chk({pfx, "_coal"}, coalesce_cnt_out, 0);
        chk({pfx, "_src"}, src_idx_out, 0);
    endtask

    task automatic rand_table(input int span);
        for (int k = 0; k < 16; k++)
            tbl[k] = int'($urandom_range(2 * span, 0)) - span;
    endtask

    int c;
    int base;
    int exp_coal;

    initial begin
        reset        = 1'b1;
        enable_in    = 1'b0;
        lms_valid_in = 1'b0;
        for (int k = 0; k < 16; k++) tbl[k] = 0;
        step(2);
        reset = 1'b0;
        chk_reset_vals("rst");

        // Constant positive coefficient, latency to commit
        for (int k = 0; k < 16; k++) tbl[k] = 96;
        enable_in = 1'b1;
        pulse_lms();
        wait_commit("t1", 600, c);
        chk("t1_latency", c, W0N + 1);
        step(1);
        chk("t1_idle", busy_out, 0);
        chk("t1_commits", n_commit, 1);

        // Linear ramp table
        for (int k = 0; k < 16; k++) tbl[k] = (k - 8) * 32;
        pulse_lms();
        wait_commit("t2", 600, c);
        step(2);

        // Quantiser boundaries mixed into random tables
        for (int r = 0; r < 3; r++) begin
            rand_table(200);
            tbl[(r + 0) % 16] = -64;
            tbl[(r + 3) % 16] = -33;
            tbl[(r + 6) % 16] = -32;
            tbl[(r + 9) % 16] = 63;
            tbl[(r + 12) % 16] = 64;
            pulse_lms();
            wait_commit("t3", 600, c);
            step(2);
        end
        rand_table(32767);
        pulse_lms();
        wait_commit("t3r", 600, c);
        step(2);

        // Several requests mid-sweep coalesce into one extra sweep
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        base = n_commit;
        rand_table(300);
        pulse_lms();
        step(int'($urandom_range(100, 10)));
        pulse_lms();
        step(int'($urandom_range(20, 2)));
        pulse_lms();
        step(int'($urandom_range(20, 2)));
        pulse_lms();
        wait_commit("t4a", 600, c);
        step(1);
        chk("t4_gap_idle", busy_out, 0);
        step(1);
        chk("t4_restart", busy_out, 1);
        wait_commit("t4b", 600, c);
        step(50);
        chk("t4_quiet", busy_out, 0);
        chk("t4_sweeps", n_commit - base, 2);
`ifdef W0_UPDATE_SCHED_COALESCE_CNT_EN
        exp_coal = 2;
`else
        exp_coal = 0;
`endif
        chk("t4_coal", coalesce_cnt_out, exp_coal);

        // Enable dropped mid-sweep with a request pending
        base = n_commit;
        pulse_lms();
        step(20);
        enable_in = 1'b0;
        pulse_lms();
        wait_commit("t5", 600, c);
        step(1);
        chk("t5_idle", busy_out, 0);
        step(30);
        chk("t5_hold", busy_out, 0);
        chk("t5_commits", n_commit - base, 1);
        enable_in = 1'b1;
        step(1);
        chk("t5_resume", busy_out, 1);
        wait_commit("t5b", 600, c);
        step(2);
        chk("t5_done", busy_out, 0);

        // Reset mid-sweep abandons the image
        rand_table(500);
        pulse_lms();
        step(101);
        chk("t6_busy_pre", busy_out, 1);
        base = n_commit;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_reset_vals("t6");
        step(600);
        chk("t6_no_commit", n_commit - base, 0);
        chk("t6_idle", busy_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
